// File: rtl/packer.sv
// Sign-magnitude fixed-point (mag x 2^-32, or exactly +/-1.0) to IEEE-754 single, normalised one shift per cycle.
// Define PACKER_ROUND_EN for round-to-nearest-even on the discarded bits; otherwise they are truncated.
module packer #(
  parameter int MAG_W   = 32,
  parameter int EXP_OFS = 95
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             start,
  input  logic             sign,
  input  logic             is_one,
  input  logic [MAG_W-1:0] mag,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result
);

  localparam int CW = $clog2(MAG_W);
  localparam logic [7:0] EXP_TOP = 8'(EXP_OFS + MAG_W - 1);

  typedef enum logic [1:0] {IDLE, NORM, PACK} state_t;

  state_t           state, state_nx;
  logic [MAG_W-1:0] shreg, shreg_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             sgn, sgn_nx;
  logic             busy_nx, done_nx;
  logic [31:0]      result_nx;
  logic [7:0]       exp_c;
  logic [30:0]      body, body_r;

  // cnt counts the shifts, so the leading one sat at bit (MAG_W-1-cnt) of mag.
  assign exp_c = EXP_TOP - 8'(cnt);
  assign body  = {exp_c, shreg[MAG_W-2 -: 23]};

`ifdef PACKER_ROUND_EN
  logic rnd;
  // A mantissa carry-out ripples into the exponent, so 0x7FFFFF rounds up to the next binade.
  assign rnd    = shreg[7] && ((shreg[6:0] != 7'd0) || shreg[8]);
  assign body_r = body + 31'(rnd);
`else
  assign body_r = body;
`endif

  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    cnt_nx    = cnt;
    sgn_nx    = sgn;
    busy_nx   = busy;
    done_nx   = 1'b0;
    result_nx = result;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_one || mag == '0) begin
            result_nx = is_one ? {sign, 8'h7F, 23'h0} : {sign, 31'h0};
            done_nx   = 1'b1;
          end else begin
            shreg_nx = mag;
            cnt_nx   = '0;
            sgn_nx   = sign;
            busy_nx  = 1'b1;
            state_nx = NORM;
          end
        end
      end
      NORM: begin
        if (!shreg[MAG_W-1]) begin
          shreg_nx = {shreg[MAG_W-2:0], 1'b0};
          cnt_nx   = cnt + CW'(1);
        end else begin
          state_nx = PACK;
        end
      end
      PACK: begin
        result_nx = {sgn, body_r};
        done_nx   = 1'b1;
        busy_nx   = 1'b0;
        state_nx  = IDLE;
      end
      default: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // Reset wins over clk_en; with clk_en low every register holds.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      sgn    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 32'h0;
    end else if (clk_en) begin
      state  <= state_nx;
      shreg  <= shreg_nx;
      cnt    <= cnt_nx;
      sgn    <= sgn_nx;
      busy   <= busy_nx;
      done   <= done_nx;
      result <= result_nx;
    end
  end

endmodule

// File: tb/tb_packer.sv
// Self-checking bench for packer: directed cases, control cases and random vectors against a real-arithmetic model.
// Latency is counted as enabled edges after the start edge until done is seen (fast path = 0, normal = k+2).
module tb_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_en;
  logic        start;
  logic        sign;
  logic        is_one;
  logic [31:0] mag;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

  packer dut (
    .clk    (clk),
    .reset_n(reset_n),
    .clk_en (clk_en),
    .start  (start),
    .sign   (sign),
    .is_one (is_one),
    .mag    (mag),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference: let the simulator's double do the normalisation, then cut it down to single.
  function automatic logic [31:0] refFloat(input logic s, input logic one, input logic [31:0] m);
    real         v;
    logic [63:0] b;
    logic [7:0]  e;
    logic [30:0] bodyv;
    logic        rnd;
    v = one ? 1.0 : real'(longint'({32'h0, m})) / 4294967296.0;
    if (v == 0.0) return {s, 31'h0};
    b = $realtobits(v);
    e = 8'(int'(b[62:52]) - 1023 + 127);
    bodyv = {e, b[51:29]};
    rnd = b[28] && ((b[27:0] != 28'd0) || b[29]);
`ifdef PACKER_ROUND_EN
    bodyv = bodyv + 31'(rnd);
`endif
    return {s, bodyv};
  endfunction

  function automatic int refLatency(input logic one, input logic [31:0] m);
    real v;
    int  k;
    if (one || m == 32'h0) return 0;
    v = real'(longint'({32'h0, m})) / 4294967296.0;
    k = 0;
    while (v < 0.5) begin
      v = v * 2.0;
      k++;
    end
    return k + 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issue one start, then wait (bounded) for done; busy must stay high until then.
  task automatic applyStimulus(input logic s, input logic one, input logic [31:0] m,
                               output logic [31:0] res, output int lat,
                               output logic busyAtDone, output logic busyOk);
    sign   = s;
    is_one = one;
    mag    = m;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    is_one = 1'b0;
    lat    = 0;
    busyOk = 1'b1;
    while (done !== 1'b1 && lat < 60) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      tick();
      lat++;
    end
    res        = result;
    busyAtDone = busy;
  endtask

  logic        dirSign [7];
  logic        dirOne  [7];
  logic [31:0] dirMag  [7];
  logic [31:0] dirRes  [7];
  int          dirLat  [7];

  initial begin
    logic [31:0] res;
    logic [31:0] m;
    logic        s, one, bAtDone, bOk;
    int          lat, dones, sel;

    dirSign = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    dirOne  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    dirMag  = '{32'h80000000, 32'h00000001, 32'h00000863, 32'h00000863,
                32'h00001234, 32'h00000000, 32'hFFFFFFFF};
`ifdef PACKER_ROUND_EN
    dirRes  = '{32'h3F000000, 32'h2F800000, 32'h35063000, 32'hB5063000,
                32'hBF800000, 32'h80000000, 32'h3F800000};
`else
    dirRes  = '{32'h3F000000, 32'h2F800000, 32'h35063000, 32'hB5063000,
                32'hBF800000, 32'h80000000, 32'h3F7FFFFF};
`endif
    dirLat  = '{2, 33, 22, 22, 0, 0, 2};

    reset_n = 1'b0;
    clk_en  = 1'b1;
    start   = 1'b0;
    sign    = 1'b0;
    is_one  = 1'b0;
    mag     = 32'h0;
    tick();
    tick();
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_done", {31'h0, done}, 32'h0);
    checkOutput("reset_result", result, 32'h0);
    reset_n = 1'b1;
    tick();

    $display("[TB] directed conversions");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(dirSign[i], dirOne[i], dirMag[i], res, lat, bAtDone, bOk);
      checkOutput($sformatf("dir%0d_result", i), res, dirRes[i]);
      checkOutput($sformatf("dir%0d_model", i), res, refFloat(dirSign[i], dirOne[i], dirMag[i]));
      checkOutput($sformatf("dir%0d_latency", i), 32'(lat), 32'(dirLat[i]));
      checkOutput($sformatf("dir%0d_busy_at_done", i), {31'h0, bAtDone}, 32'h0);
      checkOutput($sformatf("dir%0d_busy_while_norm", i), {31'h0, bOk}, 32'h1);
      tick();
      checkOutput($sformatf("dir%0d_done_pulse", i), {31'h0, done}, 32'h0);
    end

    $display("[TB] clk_en stall mid-NORM");
    sign  = 1'b0;
    mag   = 32'h00000863;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    repeat (5) begin tick(); lat++; end
    clk_en = 1'b0;
    start  = 1'b1;
    mag    = 32'h80000000;
    repeat (5) begin tick(); lat++; end
    checkOutput("stall_busy_held", {31'h0, busy}, 32'h1);
    checkOutput("stall_no_done", {31'h0, done}, 32'h0);
    start  = 1'b0;
    clk_en = 1'b1;
    while (done !== 1'b1 && lat < 80) begin tick(); lat++; end
    checkOutput("stall_latency", 32'(lat), 32'd27);
    checkOutput("stall_result", result, 32'h35063000);
    tick();

    $display("[TB] start while busy");
    sign  = 1'b0;
    mag   = 32'h00000001;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    repeat (3) begin tick(); lat++; end
    sign  = 1'b1;
    mag   = 32'h80000000;
    start = 1'b1;
    tick();
    lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 60) begin tick(); lat++; end
    checkOutput("busy_start_latency", 32'(lat), 32'd33);
    checkOutput("busy_start_result", result, 32'h2F800000);
    dones = 0;
    repeat (10) begin tick(); if (done === 1'b1) dones++; end
    checkOutput("busy_start_no_queue", 32'(dones), 32'd0);

    $display("[TB] clk_en low holds done and ignores start");
    sign   = 1'b0;
    is_one = 1'b1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    is_one = 1'b0;
    checkOutput("hold_fast_done", {31'h0, done}, 32'h1);
    clk_en = 1'b0;
    sign   = 1'b1;
    mag    = 32'h0;
    start  = 1'b1;
    tick();
    tick();
    checkOutput("hold_done_held", {31'h0, done}, 32'h1);
    checkOutput("hold_result_held", result, 32'h3F800000);
    start  = 1'b0;
    clk_en = 1'b1;
    tick();
    checkOutput("hold_done_clears", {31'h0, done}, 32'h0);
    checkOutput("hold_start_unseen", result, 32'h3F800000);

    $display("[TB] reset mid-NORM");
    sign  = 1'b0;
    mag   = 32'h00000001;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    clk_en  = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    clk_en  = 1'b1;
    checkOutput("abort_busy", {31'h0, busy}, 32'h0);
    checkOutput("abort_done", {31'h0, done}, 32'h0);
    checkOutput("abort_result", result, 32'h0);
    dones = 0;
    repeat (40) begin tick(); if (done === 1'b1) dones++; end
    checkOutput("abort_no_done", 32'(dones), 32'd0);

    $display("[TB] random back-to-back conversions");
    for (int i = 0; i < 40; i++) begin
      m   = $urandom() >> $urandom_range(0, 31);
      sel = $urandom_range(0, 9);
      one = (sel == 0);
      if (sel == 1) m = 32'h0;
      if (m == 32'h0 && sel > 1) m = 32'h1;
      s = 1'($urandom_range(0, 1));
      applyStimulus(s, one, m, res, lat, bAtDone, bOk);
      checkOutput($sformatf("rnd%0d_result m=%h", i, m), res, refFloat(s, one, m));
      checkOutput($sformatf("rnd%0d_latency m=%h", i, m), 32'(lat), 32'(refLatency(one, m)));
      checkOutput($sformatf("rnd%0d_busy_at_done", i), {31'h0, bAtDone}, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
